// File: rtl/sound_sequencer.sv
// sound_sequencer: plays clips from a 4-bit sample ROM at a programmable sample rate.
// Four clip requesters are arbitrated by fixed priority, and a higher request preempts the running clip.
`default_nettype none

module sound_sequencer #(
   parameter int unsigned CLK_DIV    = 1250,
   parameter logic [71:0] CLIP_START = {18'd196608, 18'd131072, 18'd65536, 18'd0},
   parameter logic [71:0] CLIP_END   = {18'd262143, 18'd196607, 18'd131071, 18'd65535}
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  trig,
   input  logic        stop,
   input  logic        loop_en,
   output logic [17:0] rom_addr,
   input  logic [3:0]  rom_rdata,
   output logic [3:0]  sample,
   output logic        playing,
   output logic [1:0]  clip_id,
   output logic        done
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [3:0]  SILENCE  = 4'h8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_CAPTURE = 2'd2,
      S_WAIT    = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [17:0] ptr_nxt;
   logic [15:0] div_cnt, div_nxt;
   logic [3:0]  sample_nxt;
   logic [1:0]  clip_nxt;
   logic        done_nxt;

   logic [17:0] start_tab [4];
   logic [17:0] end_tab   [4];

   for (genvar i = 0; i < 4; i++) begin : g_tab
      assign start_tab[i] = CLIP_START[18*i +: 18];
      assign end_tab[i]   = CLIP_END[18*i +: 18];
   end

   logic       trig_any;
   logic [1:0] winner;
   logic       start_ok;
   logic       period_end;

   always_comb begin
      trig_any = |trig;
      winner   = 2'd0;
      if (trig[3])      winner = 2'd3;
      else if (trig[2]) winner = 2'd2;
      else if (trig[1]) winner = 2'd1;
   end

   // Outside IDLE only a strictly higher-priority clip may take over.
   assign start_ok   = trig_any && ((state == S_IDLE) || (winner > clip_id));
   assign period_end = (div_cnt == DIV_LAST);
   assign playing    = (state != S_IDLE);

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = rom_addr;
      div_nxt    = div_cnt;
      sample_nxt = sample;
      clip_nxt   = clip_id;
      done_nxt   = 1'b0;

      if ((state != S_IDLE) && stop) begin
         state_nxt  = S_IDLE;
         sample_nxt = SILENCE;
         div_nxt    = 16'd0;
      end else if (start_ok) begin
         ptr_nxt   = start_tab[winner];
         clip_nxt  = winner;
         div_nxt   = 16'd0;
         state_nxt = S_FETCH;
      end else begin
         case (state)
            S_FETCH: begin
               div_nxt   = div_cnt + 16'd1;
               state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
               sample_nxt = rom_rdata;
               div_nxt    = div_cnt + 16'd1;
               state_nxt  = S_WAIT;
            end
            S_WAIT: begin
               if (period_end) begin
                  div_nxt = 16'd0;
                  // Comparing against the end address first keeps ptr from wrapping at 2^18-1.
                  if (rom_addr != end_tab[clip_id]) begin
                     ptr_nxt   = rom_addr + 18'd1;
                     state_nxt = S_FETCH;
                  end else if (loop_en) begin
                     ptr_nxt   = start_tab[clip_id];
                     state_nxt = S_FETCH;
                  end else begin
                     done_nxt   = 1'b1;
                     sample_nxt = SILENCE;
                     state_nxt  = S_IDLE;
                  end
               end else begin
                  div_nxt = div_cnt + 16'd1;
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         rom_addr <= 18'd0;
         div_cnt  <= 16'd0;
         sample   <= SILENCE;
         clip_id  <= 2'd0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         rom_addr <= ptr_nxt;
         div_cnt  <= div_nxt;
         sample   <= sample_nxt;
         clip_id  <= clip_nxt;
         done     <= done_nxt;
      end
   end

endmodule

`default_nettype wire
